// File: rtl/car_plot_arbiter.sv
// car_plot_arbiter: round-robin owner of the shared VGA plot port, one car per pass, with hold timeout
module car_plot_arbiter #(
  parameter int NUM_CARS = 4,
  parameter int MAX_HOLD = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CARS-1:0]     req,
  input  logic [NUM_CARS-1:0]     pix_valid,
  input  logic [NUM_CARS-1:0]     pix_last,
  input  logic [15*NUM_CARS-1:0]  coord_in,
  input  logic [9*NUM_CARS-1:0]   colour_in,
  output logic [NUM_CARS-1:0]     grant,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [8:0]              vga_colour,
  output logic                    vga_plot,
  output logic                    busy,
  output logic                    timeout_err
);
  localparam int PW = NUM_CARS > 1 ? $clog2(NUM_CARS) : 1;
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state;
  logic [PW-1:0] ptr, g, win, nxt;
  logic [HW-1:0] hold_cnt;
  logic [14:0] coord_g;
  logic [8:0] colour_g;
  logic req_g, valid_g, last_g, done_g, at_max;
  always_comb begin
    win = ptr;
    for (int i = NUM_CARS - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_CARS]) win = PW'((int'(ptr) + i) % NUM_CARS);
  end
  assign coord_g  = coord_in[15*g +: 15];
  assign colour_g = colour_in[9*g +: 9];
  assign req_g    = req[g];
  assign valid_g  = pix_valid[g];
  assign last_g   = pix_last[g];
  assign done_g   = valid_g & last_g;
  assign at_max   = hold_cnt == HW'(MAX_HOLD - 1);
  assign nxt      = (int'(g) == NUM_CARS - 1) ? '0 : g + 1'b1;
  assign busy     = state == GRANT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= '0;
      g           <= '0;
      hold_cnt    <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          state    <= GRANT;
          g        <= win;
          grant    <= NUM_CARS'(1) << win;
          hold_cnt <= '0;
        end
        GRANT: begin
          vga_x      <= coord_g[14:7];
          vga_y      <= coord_g[6:0];
          vga_colour <= colour_g;
          vga_plot   <= valid_g & req_g;
          if (!req_g || done_g || at_max) begin
            state <= GAP;
            grant <= '0;
            ptr   <= nxt;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (req_g && !done_g && at_max) timeout_err <= 1'b1;
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_car_plot_arbiter.sv
// tb_car_plot_arbiter: directed checks of arbitration order, pixel forwarding, gaps, timeout and reset
module tb_car_plot_arbiter;
  logic clk, reset;
  logic [3:0] req, pix_valid, pix_last;
  logic [59:0] coord_in;
  logic [35:0] colour_in;
  logic [3:0] grant_a, grant_b;
  logic [7:0] vga_x_a, vga_x_b;
  logic [6:0] vga_y_a, vga_y_b;
  logic [8:0] vga_colour_a, vga_colour_b;
  logic vga_plot_a, vga_plot_b, busy_a, busy_b, timeout_err_a, timeout_err_b;
  int total = 0;
  int bad = 0;
  car_plot_arbiter #(.NUM_CARS(4), .MAX_HOLD(1024)) dut_a (
    .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid), .pix_last(pix_last),
    .coord_in(coord_in), .colour_in(colour_in), .grant(grant_a), .vga_x(vga_x_a),
    .vga_y(vga_y_a), .vga_colour(vga_colour_a), .vga_plot(vga_plot_a), .busy(busy_a),
    .timeout_err(timeout_err_a)
  );
  car_plot_arbiter #(.NUM_CARS(4), .MAX_HOLD(16)) dut_b (
    .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid), .pix_last(pix_last),
    .coord_in(coord_in), .colour_in(colour_in), .grant(grant_b), .vga_x(vga_x_b),
    .vga_y(vga_y_b), .vga_colour(vga_colour_b), .vga_plot(vga_plot_b), .busy(busy_b),
    .timeout_err(timeout_err_b)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_pix(input int c, input logic v, input logic l, input logic [7:0] x,
                         input logic [6:0] y, input logic [8:0] col);
    pix_valid[c] = v;
    pix_last[c] = l;
    coord_in[15*c +: 15] = {x, y};
    colour_in[9*c +: 9] = col;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    pix_valid = '0;
    pix_last = '0;
    coord_in = '0;
    colour_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic pass(input int c, input int n, input bit use_last, input int x0, input int y0,
                      input string tag, output int dead);
    int errs;
    int plots;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [8:0] ec;
    logic [3:0] eg;
    errs = 0;
    plots = 0;
    dead = 0;
    while (grant_a == '0 && dead < 50) begin
      dead++;
      @(negedge clk);
    end
    chk({tag, "_grant"}, 32'(grant_a), 32'(1 << c));
    for (int k = 0; k < n; k++) begin
      ex = 8'(x0 + k % 20);
      ey = 7'(y0 + k / 20);
      ec = 9'(k + 64 * c);
      eg = (use_last && k == n - 1) ? 4'b0 : 4'(1 << c);
      set_pix(c, 1'b1, use_last && k == n - 1, ex, ey, ec);
      @(negedge clk);
      if (vga_plot_a) plots++;
      if (vga_x_a !== ex || vga_y_a !== ey || vga_colour_a !== ec || grant_a !== eg) errs++;
    end
    set_pix(c, 1'b0, 1'b0, '0, '0, '0);
    if (!use_last) begin
      req[c] = 1'b0;
      @(negedge clk);
      chk({tag, "_drop_plot"}, 32'(vga_plot_a), 0);
    end
    chk({tag, "_gnt_off"}, 32'(grant_a), 0);
    chk({tag, "_pix"}, errs, 0);
    chk({tag, "_plots"}, plots, n);
  endtask
  initial begin
    int d;
    int cnt;
    int w;
    reset = 1'b1;
    req = '0;
    pix_valid = '0;
    pix_last = '0;
    coord_in = '0;
    colour_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant_a), 0);
    chk("rst_x", 32'(vga_x_a), 0);
    chk("rst_y", 32'(vga_y_a), 0);
    chk("rst_colour", 32'(vga_colour_a), 0);
    chk("rst_plot", 32'(vga_plot_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_terr", 32'(timeout_err_a), 0);
    reset = 1'b0;
    req = 4'b0010;
    pass(1, 400, 1, 5, 60, "single", d);
    chk("single_latency", d, 1);
    chk("single_busy_off", 32'(busy_a), 0);
    chk("single_terr", 32'(timeout_err_a), 0);
    req = '0;
    @(negedge clk);
    chk("single_gap_plot", 32'(vga_plot_a), 0);
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 4; j++) set_pix(j, 1'b1, 1'b1, 8'hFF, 7'h7F, 9'h1FF);
    pass(0, 4, 1, 0, 0, "cont0", d);
    pass(1, 4, 1, 30, 10, "cont1", d);
    chk("cont1_dead", d, 2);
    pass(2, 4, 1, 60, 20, "cont2", d);
    chk("cont2_dead", d, 2);
    pass(3, 4, 1, 90, 30, "cont3", d);
    chk("cont3_dead", d, 2);
    pass(0, 4, 1, 0, 0, "cont4", d);
    chk("cont4_dead", d, 2);
    do_reset();
    req = 4'b0100;
    pass(2, 2, 1, 3, 3, "fair2", d);
    req = 4'b0101;
    pass(0, 2, 1, 4, 4, "fair0", d);
    chk("fair0_dead", d, 2);
    do_reset();
    req = 4'b1000;
    pass(3, 5, 0, 11, 12, "drop3", d);
    req = 4'b1001;
    pass(0, 1, 1, 13, 14, "drop_next0", d);
    do_reset();
    req = 4'b0011;
    @(negedge clk);
    cnt = 0;
    while (grant_b == 4'b0001 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_hold_cycles", cnt, 16);
    chk("to_terr_set", 32'(timeout_err_b), 1);
    w = 0;
    while (grant_b == '0 && w < 10) begin
      w++;
      @(negedge clk);
    end
    chk("to_next_car1", 32'(grant_b), 32'(4'b0010));
    chk("to_a_no_terr", 32'(timeout_err_a), 0);
    req = '0;
    repeat (5) @(negedge clk);
    chk("to_terr_sticky", 32'(timeout_err_b), 1);
    do_reset();
    req = 4'b0010;
    set_pix(1, 1'b1, 1'b0, 8'd7, 7'd7, 9'd7);
    repeat (20) @(negedge clk);
    chk("rmp_grant_before", 32'(grant_a), 32'(4'b0010));
    chk("rmp_plot_before", 32'(vga_plot_a), 1);
    chk("rmp_terr_b_before", 32'(timeout_err_b), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rmp_grant", 32'(grant_a), 0);
    chk("rmp_plot", 32'(vga_plot_a), 0);
    chk("rmp_busy", 32'(busy_a), 0);
    chk("rmp_terr_b", 32'(timeout_err_b), 0);
    reset = 1'b0;
    set_pix(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("rmp_regrant", 32'(grant_a), 32'(4'b0010));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
